// File: rtl/mux_scan_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_reg_if
// Brief    : Data/control bundle between a multi-source bus and mux_scan_reg.
// Revision : 1.0
// ============================================================================
interface mux_scan_reg_if #(
   parameter int WIDTH    = 4,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
);
   logic [CHANNELS*WIDTH-1:0] I;
   logic [SEL_W-1:0]          sel;
   logic                      sel_load;
   logic                      mode;
   logic                      enable;
   logic [CHANNELS-1:0]       mask;
   logic [WIDTH-1:0]          Out;
   logic [SEL_W-1:0]          out_ch;
   logic                      out_valid;
   logic                      wrap;

   modport master (
      output I, sel, sel_load, mode, enable, mask,
      input  Out, out_ch, out_valid, wrap
   );

   modport slave (
      input  I, sel, sel_load, mode, enable, mask,
      output Out, out_ch, out_valid, wrap
   );
endinterface
`default_nettype wire

// File: rtl/mux_scan_reg.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_reg
// Brief    : Registered N:1 multiplexer with manual select and dwell-timed
//            round-robin scan over a channel skip mask.
// Revision : 1.0
// ============================================================================
module mux_scan_reg #(
   parameter int WIDTH    = 4,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2,
   parameter int DWELL    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   mux_scan_reg_if.slave bus
);
   localparam int                 c_CNT_W      = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int                 c_SLOTS      = 2 ** SEL_W;
   localparam logic [c_CNT_W-1:0] c_DWELL_LAST = c_CNT_W'(DWELL - 1);
   localparam logic [SEL_W:0]     c_CHANNELS   = (SEL_W + 1)'(CHANNELS);

   logic [SEL_W-1:0]   r_cur_ch;
   logic [c_CNT_W-1:0] r_dwell;
   logic               r_mode;
   logic               r_wrap_pend;
   logic [WIDTH-1:0]   r_out;
   logic [SEL_W-1:0]   r_out_ch;
   logic               r_out_valid;
   logic               r_wrap;

   logic [WIDTH-1:0]   w_ch_data [c_SLOTS];
   logic [c_SLOTS-1:0] w_mask_pad;
   logic [SEL_W-1:0]   w_next_ch;
   logic [SEL_W:0]     w_idx;
   logic               w_found;
   logic               w_mask_any;
   logic               w_load;
   logic               w_mode_chg;
   logic               w_scan_run;
   logic               w_dwell_end;
   logic               w_advance;
   logic               w_out_upd;

   // Pad the channel array to a power of two so any select value indexes safely.
   for (genvar k = 0; k < c_SLOTS; k++) begin : g_unpack
      if (k < CHANNELS) begin : g_live
         assign w_ch_data[k]  = bus.I[k*WIDTH +: WIDTH];
         assign w_mask_pad[k] = bus.mask[k];
      end else begin : g_pad
         assign w_ch_data[k]  = '0;
         assign w_mask_pad[k] = 1'b0;
      end
   end

   // First set mask bit strictly after r_cur_ch, wrapping; falls back to itself.
   always_comb begin
      w_next_ch = r_cur_ch;
      w_found   = 1'b0;
      w_idx     = '0;
      for (int k = 1; k <= CHANNELS; k++) begin
         w_idx = {1'b0, r_cur_ch} + (SEL_W + 1)'(k);
         if (w_idx >= c_CHANNELS) begin
            w_idx = w_idx - c_CHANNELS;
         end
         if (!w_found && w_mask_pad[w_idx[SEL_W-1:0]]) begin
            w_next_ch = w_idx[SEL_W-1:0];
            w_found   = 1'b1;
         end
      end
   end

   assign w_mask_any  = |bus.mask;
   assign w_load      = bus.sel_load && ({1'b0, bus.sel} < c_CHANNELS);
   assign w_mode_chg  = bus.mode != r_mode;
   assign w_scan_run  = bus.mode && bus.enable && w_mask_any;
   assign w_dwell_end = r_dwell == c_DWELL_LAST;
   assign w_advance   = w_scan_run && w_dwell_end && !w_load && !w_mode_chg;
   assign w_out_upd   = bus.enable && (!bus.mode || w_mask_any);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cur_ch <= '0;
         r_dwell  <= '0;
         r_mode   <= 1'b0;
      end else begin
         r_mode <= bus.mode;
         if (w_load) begin
            r_cur_ch <= bus.sel;
            r_dwell  <= '0;
         end else if (w_mode_chg) begin
            r_dwell <= '0;
         end else if (w_scan_run) begin
            if (w_dwell_end) begin
               r_dwell  <= '0;
               r_cur_ch <= w_next_ch;
            end else begin
               r_dwell <= r_dwell + 1'b1;
            end
         end
      end
   end

   // A wrap is remembered until the first sample of the new channel is emitted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrap_pend <= 1'b0;
         r_out       <= '0;
         r_out_ch    <= '0;
         r_out_valid <= 1'b0;
         r_wrap      <= 1'b0;
      end else begin
         if (w_advance) begin
            r_wrap_pend <= (w_next_ch <= r_cur_ch);
         end else if (w_load || w_mode_chg || w_out_upd) begin
            r_wrap_pend <= 1'b0;
         end
         if (w_out_upd) begin
            r_out       <= w_ch_data[r_cur_ch];
            r_out_ch    <= r_cur_ch;
            r_out_valid <= 1'b1;
            r_wrap      <= r_wrap_pend;
         end else begin
            r_out_valid <= 1'b0;
            r_wrap      <= 1'b0;
         end
      end
   end

   assign bus.Out       = r_out;
   assign bus.out_ch    = r_out_ch;
   assign bus.out_valid = r_out_valid;
   assign bus.wrap      = r_wrap;
endmodule
`default_nettype wire

// File: tb/tb_mux_scan_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_scan_reg
// Brief    : Directed-vector bench for mux_scan_reg (4-channel and 3-channel).
// Revision : 1.0
// ============================================================================
module tb_mux_scan_reg;
   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fails  = 0;

   mux_scan_reg_if #(.WIDTH(4), .CHANNELS(4), .SEL_W(2)) bus_a ();
   mux_scan_reg_if #(.WIDTH(4), .CHANNELS(3), .SEL_W(2)) bus_b ();

   mux_scan_reg #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DWELL(2)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   mux_scan_reg #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .DWELL(2)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic exp_a(input string tag, input logic [3:0] o, input logic [1:0] c,
                        input logic v, input logic w);
      check($sformatf("%s.Out", tag),       32'(bus_a.Out),       32'(o));
      check($sformatf("%s.out_ch", tag),    32'(bus_a.out_ch),    32'(c));
      check($sformatf("%s.out_valid", tag), 32'(bus_a.out_valid), 32'(v));
      check($sformatf("%s.wrap", tag),      32'(bus_a.wrap),      32'(w));
   endtask

   task automatic exp_b(input string tag, input logic [3:0] o, input logic [1:0] c);
      check($sformatf("%s.Out", tag),    32'(bus_b.Out),    32'(o));
      check($sformatf("%s.out_ch", tag), 32'(bus_b.out_ch), 32'(c));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Channels: ch0=E, ch1=A, ch2=C, ch3=B.
   logic [3:0] scan_out  [10] = '{4'hE, 4'hE, 4'hA, 4'hA, 4'hC, 4'hC, 4'hB, 4'hB, 4'hE, 4'hE};
   logic [1:0] scan_ch   [10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
   logic       scan_wrap [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   logic [3:0] skip_out  [7]  = '{4'hB, 4'hA, 4'hA, 4'hB, 4'hB, 4'hA, 4'hA};
   logic [1:0] skip_ch   [7]  = '{2'd3, 2'd1, 2'd1, 2'd3, 2'd3, 2'd1, 2'd1};
   logic       skip_wrap [7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n          = 1'b0;
      bus_a.I        = 16'hBCAE;
      bus_a.sel      = 2'd0;
      bus_a.sel_load = 1'b0;
      bus_a.mode     = 1'b0;
      bus_a.enable   = 1'b0;
      bus_a.mask     = 4'h0;
      bus_b.I        = 12'hCAE;
      bus_b.sel      = 2'd0;
      bus_b.sel_load = 1'b0;
      bus_b.mode     = 1'b0;
      bus_b.enable   = 1'b0;
      bus_b.mask     = 3'h0;

      tick();
      exp_a("reset", 4'h0, 2'd0, 1'b0, 1'b0);
      rst_n = 1'b1;

      // Manual select: two edges from sel_load to the new channel's data.
      bus_a.enable   = 1'b1;
      bus_a.sel      = 2'd3;
      bus_a.sel_load = 1'b1;
      tick();
      bus_a.sel_load = 1'b0;
      tick();
      exp_a("man_sel3", 4'hB, 2'd3, 1'b1, 1'b0);
      bus_a.sel      = 2'd2;
      bus_a.sel_load = 1'b1;
      tick();
      bus_a.sel_load = 1'b0;
      tick();
      exp_a("man_sel2", 4'hC, 2'd2, 1'b1, 1'b0);

      // Park on channel 0, then enter scan with output disabled for that edge.
      bus_a.sel      = 2'd0;
      bus_a.sel_load = 1'b1;
      tick();
      bus_a.sel_load = 1'b0;
      bus_a.enable   = 1'b0;
      bus_a.mode     = 1'b1;
      bus_a.mask     = 4'hF;
      tick();
      check("scan_entry.out_valid", 32'(bus_a.out_valid), 32'd0);
      bus_a.enable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         exp_a($sformatf("scan[%0d]", i), scan_out[i], scan_ch[i], 1'b1, scan_wrap[i]);
      end

      // Freeze mid-dwell on channel 1 and resume.
      tick();
      exp_a("frz_pre", 4'hA, 2'd1, 1'b1, 1'b0);
      bus_a.enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         exp_a($sformatf("frz[%0d]", i), 4'hA, 2'd1, 1'b0, 1'b0);
      end
      bus_a.enable = 1'b1;
      tick();
      exp_a("frz_resume", 4'hA, 2'd1, 1'b1, 1'b0);
      tick();
      exp_a("frz_next", 4'hC, 2'd2, 1'b1, 1'b0);

      // sel_load on the dwell-end edge wins over the scan successor.
      bus_a.sel      = 2'd2;
      bus_a.sel_load = 1'b1;
      tick();
      exp_a("coll_edge", 4'hC, 2'd2, 1'b1, 1'b0);
      bus_a.sel_load = 1'b0;
      tick();
      exp_a("coll_d0", 4'hC, 2'd2, 1'b1, 1'b0);
      tick();
      exp_a("coll_d1", 4'hC, 2'd2, 1'b1, 1'b0);
      tick();
      exp_a("coll_succ", 4'hB, 2'd3, 1'b1, 1'b0);

      // Skip mask applies at the next advance.
      bus_a.mask = 4'b1010;
      for (int i = 0; i < 7; i++) begin
         tick();
         exp_a($sformatf("skip[%0d]", i), skip_out[i], skip_ch[i], 1'b1, skip_wrap[i]);
      end

      bus_a.mask = 4'h0;
      tick();
      exp_a("mask0_a", 4'hA, 2'd1, 1'b0, 1'b0);
      tick();
      exp_a("mask0_b", 4'hA, 2'd1, 1'b0, 1'b0);

      // Async reset mid-dwell, observed before any clock edge.
      bus_a.mask = 4'hF;
      tick();
      exp_a("pre_rst", 4'hB, 2'd3, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      exp_a("async_rst", 4'h0, 2'd0, 1'b0, 1'b0);
      bus_a.enable = 1'b0;
      tick();
      rst_n = 1'b1;

      // Three-channel instance: out-of-range select is ignored.
      bus_b.enable   = 1'b1;
      bus_b.sel      = 2'd1;
      bus_b.sel_load = 1'b1;
      tick();
      bus_b.sel_load = 1'b0;
      tick();
      exp_b("b_sel1", 4'hA, 2'd1);
      bus_b.sel      = 2'd3;
      bus_b.sel_load = 1'b1;
      tick();
      bus_b.sel_load = 1'b0;
      tick();
      exp_b("b_sel3_ignored", 4'hA, 2'd1);
      bus_b.sel      = 2'd2;
      bus_b.sel_load = 1'b1;
      tick();
      bus_b.sel_load = 1'b0;
      tick();
      exp_b("b_sel2", 4'hC, 2'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
`default_nettype wire
